// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cs/we/oe single-port memory bus: responder
// state encoding, wait-state counter width and the default bus geometry
// used by the initiator, the responder and the datapath.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Wait-state counter width; WAIT_STATES must fit in 0..7.
    localparam int WS_W = 3;

    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_DATA_WIDTH = 16;

    // Counter preload on accept: WAIT is left on the edge where the count is 0,
    // so N wait states need a preload of N-1.
    function automatic logic [WS_W-1:0] ws_load(input int ws);
        if (ws == 0) begin
            return '0;
        end
        return WS_W'(ws - 1);
    endfunction

endpackage

// File: rtl/mem_array_core.sv
// DEPTH x DATA_WIDTH storage with one shared address, a write port and a
// registered read port. The read register holds the last completed read and
// is the only resettable state here; the array contents are never cleared.
module mem_array_core
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Array write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data only moves on a read access; otherwise it holds.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Responder end of the cs/we/oe memory bus with a wait-state sequencer and a
// one-cycle ready strobe. Build option MEM_BUS_RESPONDER_WRPROT_EN rejects
// writes below PROT_LIMIT and flags them on err alongside ready.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int          DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int          WAIT_STATES = 1,
    parameter int unsigned PROT_LIMIT  = 'h100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs_input,
    input  logic                  we,
    input  logic                  oe,
    output logic                  ready,
    output logic                  err
);

`ifdef MEM_BUS_RESPONDER_WRPROT_EN
    localparam bit WRPROT_ON = 1'b1;
`else
    localparam bit WRPROT_ON = 1'b0;
`endif

    localparam logic [WS_W-1:0]     WS_LOAD        = ws_load(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0] PROT_LIMIT_EXT = (ADDR_WIDTH + 1)'(PROT_LIMIT);

    resp_state_t           state_q, state_d;
    logic [WS_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_l_q, addr_l_d;
    logic                  we_l_q, we_l_d;
    logic [DATA_WIDTH-1:0] wdata_l_q, wdata_l_d;

    logic                  commit_en;
    logic                  commit_we;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0] commit_wdata;
    logic                  prot_hit;
    logic [DATA_WIDTH-1:0] rdata;

    // State, counter and latched request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_l_q  <= '0;
            we_l_q    <= 1'b0;
            wdata_l_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_l_q  <= addr_l_d;
            we_l_q    <= we_l_d;
            wdata_l_q <= wdata_l_d;
        end
    end

    // Next state: the bus is only sampled in IDLE; WAIT and RESP run to completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_l_d  = addr_l_q;
        we_l_d    = we_l_q;
        wdata_l_d = wdata_l_q;
        case (state_q)
            IDLE: begin
                if (cs_input) begin
                    addr_l_d  = addr;
                    we_l_d    = we;
                    wdata_l_d = data;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = WS_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs and the array access fired on the edge that enters RESP. With no
    // wait states that edge is the accept edge, so the live bus is used because
    // the latches only load on that same edge.
    always_comb begin
        commit_en    = 1'b0;
        commit_we    = we_l_q;
        commit_addr  = addr_l_q;
        commit_wdata = wdata_l_q;
        if (state_q == IDLE && cs_input && WAIT_STATES == 0) begin
            commit_en    = 1'b1;
            commit_we    = we;
            commit_addr  = addr;
            commit_wdata = data;
        end else if (state_q == WAIT && cnt_q == '0) begin
            commit_en = 1'b1;
        end
        prot_hit = WRPROT_ON && commit_we && ({1'b0, commit_addr} < PROT_LIMIT_EXT);
        ready    = (state_q == RESP);
        err      = WRPROT_ON && (state_q == RESP) && we_l_q
                   && ({1'b0, addr_l_q} < PROT_LIMIT_EXT);
    end

    mem_array_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .en    (commit_en && !prot_hit),
        .we    (commit_we),
        .addr  (commit_addr),
        .wdata (commit_wdata),
        .rdata (rdata)
    );

    // Drive only for an outright read; any write (even with oe high) leaves the bus free.
    assign data = (cs_input && oe && !we) ? rdata : 'z;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: three responders with 1, 0 and 3 wait states, each on its
// own bus with a bench-side driver, exercised one transaction at a time.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst     [3];
    logic        cs      [3];
    logic        we      [3];
    logic        oe      [3];
    logic        drv_en  [3];
    logic [15:0] drv_val [3];
    logic [13:0] addr    [3];
    logic        ready   [3];
    logic        err     [3];
    wire  [15:0] bus0, bus1, bus2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign bus0 = drv_en[0] ? drv_val[0] : 'z;
    assign bus1 = drv_en[1] ? drv_val[1] : 'z;
    assign bus2 = drv_en[2] ? drv_val[2] : 'z;

    mem_bus_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst[0]), .addr(addr[0]), .data(bus0),
        .cs_input(cs[0]), .we(we[0]), .oe(oe[0]), .ready(ready[0]), .err(err[0]));
    mem_bus_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst[1]), .addr(addr[1]), .data(bus1),
        .cs_input(cs[1]), .we(we[1]), .oe(oe[1]), .ready(ready[1]), .err(err[1]));
    mem_bus_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst[2]), .addr(addr[2]), .data(bus2),
        .cs_input(cs[2]), .we(we[2]), .oe(oe[2]), .ready(ready[2]), .err(err[2]));

    function automatic logic [15:0] bus_of(input int i);
        case (i)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs(input int i);
        cs[i] = 1'b0; we[i] = 1'b0; oe[i] = 1'b0; drv_en[i] = 1'b0;
    endtask

    // One bus transaction. lat counts edges from accept (inclusive) to the
    // ready cycle; -1 means ready never came within the budget.
    task automatic xact(input int i, input bit w, input bit o, input bit hold,
                        input logic [13:0] a, input logic [15:0] d,
                        output int lat, output logic e, output logic [15:0] dq,
                        output logic [15:0] pre);
        @(negedge clk);
        addr[i] = a; we[i] = w; oe[i] = o; cs[i] = 1'b1;
        drv_en[i] = w; drv_val[i] = d;
        #1 pre = bus_of(i);
        @(posedge clk);
        lat = -1; e = 1'b0; dq = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!hold) idle_inputs(i);
            #1;
            if (ready[i]) begin
                lat = k; e = err[i]; dq = bus_of(i);
                break;
            end
            @(posedge clk);
        end
        idle_inputs(i);
        @(posedge clk);
        #1 chk("ready_one_cycle", {31'b0, ready[i]}, 32'd0);
        $display("[TB] inst%0d %s addr=%h wdata=%h lat=%0d err=%b rdata=%h",
                 i, w ? "WR" : "RD", a, d, lat, e, dq);
    endtask

    initial begin
        int          lat, pulses;
        logic        e;
        logic [15:0] dq, pre, v0;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; idle_inputs(i); drv_val[i] = '0; addr[i] = '0;
        end

        // Reset state
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", {31'b0, ready[i]}, 32'd0);
            chk("rst_err",   {31'b0, err[i]},   32'd0);
        end
        cs[0] = 1'b1; oe[0] = 1'b1;
        #1 chk("rst_rdata_on_bus", {16'b0, bus0}, 32'h0);
        idle_inputs(0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // WAIT_STATES=1: write then read back
        xact(0, 1, 0, 0, 14'h100, 16'h110C, lat, e, dq, pre);
        chk("ws1_wr_lat", lat, 32'd2);
        chk("ws1_wr_err", {31'b0, e}, 32'd0);
        xact(0, 0, 1, 1, 14'h100, 16'h0, lat, e, dq, pre);
        chk("ws1_rd_lat", lat, 32'd2);
        chk("ws1_rd_data", {16'b0, dq}, 32'h110C);

        // WAIT_STATES=0: preload, read, bus release
        xact(1, 1, 0, 0, 14'h10B, 16'h0005, lat, e, dq, pre);
        chk("ws0_wr_lat", lat, 32'd1);
        xact(1, 0, 1, 1, 14'h10B, 16'h0, lat, e, dq, pre);
        chk("ws0_rd_lat", lat, 32'd1);
        chk("ws0_rd_data", {16'b0, dq}, 32'h0005);
        @(negedge clk);
        cs[1] = 1'b1; we[1] = 1'b0; oe[1] = 1'b0; drv_en[1] = 1'b1; drv_val[1] = 16'h7000;
        #1 chk("ws0_no_drive_oe0", {16'b0, bus1}, 32'h7000);
        idle_inputs(1);

        // we=1 with oe=1: write, responder stays off the bus
        xact(1, 1, 1, 0, 14'h10A, 16'h7000, lat, e, dq, pre);
        chk("weoe_bus_clean", {16'b0, pre}, 32'h7000);
        chk("weoe_lat", lat, 32'd1);
        xact(1, 0, 1, 1, 14'h10A, 16'h0, lat, e, dq, pre);
        chk("weoe_readback", {16'b0, dq}, 32'h7000);

        // Reset inside the ready cycle takes effect without a clock edge
        @(negedge clk);
        addr[1] = 14'h10B; we[1] = 1'b0; oe[1] = 1'b1; cs[1] = 1'b1;
        @(negedge clk);
        #1 chk("ws0_ready_before_rst", {31'b0, ready[1]}, 32'd1);
        rst[1] = 1'b1;
        #1 chk("async_rst_ready", {31'b0, ready[1]}, 32'd0);
        chk("async_rst_rdata", {16'b0, bus1}, 32'h0);
        idle_inputs(1);
        #1 rst[1] = 1'b0;
        $display("[TB] inst1 async reset during ready cycle");

        // WAIT_STATES=3: cs dropped during WAIT still completes
        xact(2, 1, 0, 0, 14'h10F, 16'hFFFF, lat, e, dq, pre);
        chk("ws3_csdrop_lat", lat, 32'd4);
        xact(2, 0, 1, 1, 14'h10F, 16'h0, lat, e, dq, pre);
        chk("ws3_rd_lat", lat, 32'd4);
        chk("ws3_rd_data", {16'b0, dq}, 32'hFFFF);

        // Reset mid-WAIT drops the pending write
        xact(2, 1, 0, 0, 14'h10D, 16'h0000, lat, e, dq, pre);
        chk("ws3_preload_lat", lat, 32'd4);
        @(negedge clk);
        addr[2] = 14'h10D; we[2] = 1'b1; cs[2] = 1'b1; drv_en[2] = 1'b1; drv_val[2] = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        idle_inputs(2);
        rst[2] = 1'b1;
        #1 chk("midwait_rst_ready", {31'b0, ready[2]}, 32'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ready[2]) pulses++;
        end
        chk("midwait_no_ready", pulses, 32'd0);
        $display("[TB] inst2 reset mid-WAIT on write 1234 to 10D, ready pulses=%0d", pulses);
        xact(2, 0, 1, 1, 14'h10D, 16'h0, lat, e, dq, pre);
        chk("midwait_rd_lat", lat, 32'd4);
        chk("midwait_rd_data", {16'b0, dq}, 32'h0000);

`ifdef MEM_BUS_RESPONDER_WRPROT_EN
        // Write protection below PROT_LIMIT
        xact(0, 0, 1, 1, 14'h0FF, 16'h0, lat, e, dq, v0);
        v0 = dq;
        xact(0, 1, 0, 0, 14'h0FF, 16'hBEEF, lat, e, dq, pre);
        chk("prot_lat", lat, 32'd2);
        chk("prot_err", {31'b0, e}, 32'd1);
        xact(0, 0, 1, 1, 14'h0FF, 16'h0, lat, e, dq, pre);
        chk("prot_unchanged", {16'b0, dq}, {16'b0, v0});
        chk("prot_rd_err", {31'b0, e}, 32'd0);
        xact(0, 1, 0, 0, 14'h100, 16'h4242, lat, e, dq, pre);
        chk("unprot_err", {31'b0, e}, 32'd0);
        xact(0, 0, 1, 1, 14'h100, 16'h0, lat, e, dq, pre);
        chk("unprot_data", {16'b0, dq}, 32'h4242);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Synthesizable responder (slave) end of the cs/we/oe single-port memory bus that the CPU controller drives as initiator.
- Owns a DEPTH x DATA_WIDTH storage array and a shared bidirectional data bus.
- Adds a configurable wait-state sequencer and a one-cycle `ready` strobe, so the initiator can run against slow memory and still interoperate with zero-wait timing.

Parameters:
- ADDR_WIDTH, 14: address bus width; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16: word width.
- WAIT_STATES, 1: extra cycles between accept and response; legal range 0..7.
- PROT_LIMIT, 'h100: first writable address; used only with WRPROT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  ADDR_WIDTH  word address from initiator (MAR).
- data  inout  DATA_WIDTH  shared data bus; driven by the responder only per the drive rule below.
- cs_input  input  1  chip select; a request is presented while high.
- we  input  1  write enable; 1 = write, 0 = read.
- oe  input  1  output enable; 1 = initiator has released the bus.
- ready  output  1  one-cycle strobe: current transaction complete.
- err  output  1  one-cycle strobe with ready: write rejected (WRPROT_EN only).

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, ready=0, err=0, rdata=0, latched addr/we/wdata=0. Storage array is not cleared.
- States: IDLE, WAIT, RESP.
- Accept (IDLE): at any posedge with cs_input=1, latch addr, we and data (the write data).
  - If WAIT_STATES=0, go to RESP.
  - Otherwise load cnt=WAIT_STATES-1 and go to WAIT.
- WAIT: decrement cnt each posedge. At cnt==0, go to RESP on that edge.
- Commit: on the edge entering RESP, perform the access.
  - Latched write: mem[addr_l] <= wdata_l.
  - Latched read: rdata <= mem[addr_l].
- RESP: ready=1 for exactly this one cycle; next edge always returns to IDLE.
- Latency: accept edge to ready-high cycle = WAIT_STATES+1 edges. An initiator that holds cs_input continuously re-issues every WAIT_STATES+2 cycles.
- In-flight requests ignore the bus: cs_input, addr, we and data are not sampled in WAIT or RESP. A cs_input drop mid-WAIT does not abort the transaction; it completes and ready still pulses.
- Drive rule: data = rdata when cs_input && oe && !we, otherwise high-Z.
  - The driven value is the last completed read and is stale until ready.
  - The responder never drives while we=1, so there is no contention with the initiator's write drive (oe=0).
- we=1 and oe=1 together: treated as a write; the bus is not driven.
- Reset mid-transaction: the pending write is dropped (array unchanged), state returns to IDLE, and ready stays low.
- Address decode: full decode with no aliasing. Out-of-range is impossible because DEPTH = 2**ADDR_WIDTH.

Optional Feature:
- Macro: MEM_BUS_RESPONDER_WRPROT_EN.
- Defined: a write with addr_l < PROT_LIMIT is not committed. err=1 during its RESP cycle alongside ready, and rdata is unchanged. Reads are never protected.
- Undefined: all writes commit, err is tied 0, and PROT_LIMIT is unused.

Decomposition:
- Package mem_bus_pkg:
  - state enum resp_state_t {IDLE, WAIT, RESP};
  - localparam WS_W=3 (cnt width);
  - default ADDR_WIDTH/DATA_WIDTH constants shared with the CPU controller and the ALU-side datapath.
- Sub-module mem_array_core: plain clocked array with a write port and a registered read port. The FSM, counter, tristate and protection logic stay in the top.

Test Plan:
- WAIT_STATES=1: write 'h110C at 'h100 (cs=1, we=1, oe=0 for one cycle) -> ready high exactly 2 edges after accept, err=0. Then read 'h100 with oe=1 -> data bus = 'h110C in the ready cycle.
- WAIT_STATES=0: read 'h10B after preload 'h0005 -> ready on the edge after accept and data='h0005. Bus is Z whenever oe=0 or we=1.
- cs_input dropped during WAIT (WAIT_STATES=3) on a write of 'hFFFF to 'h10F -> ready still pulses 4 edges after accept and mem['h10F]='hFFFF.
- rst asserted mid-WAIT on a write of 'h1234 to 'h10D (old value 'h0000) -> ready never pulses; a later read of 'h10D returns 'h0000. The rst effect is immediate, not clock-aligned.
- With MEM_BUS_RESPONDER_WRPROT_EN, PROT_LIMIT='h100: write 'hBEEF to 'h0FF -> ready=1 and err=1 in the same cycle; a read of 'h0FF returns the prior value. A write to 'h100 gives err=0 and commits.
- we=1, oe=1 simultaneously with a bench driver on data: write 'h7000 to 'h10A -> no X on the bus (responder Z), and mem['h10A]='h7000.
